multiword_add_seq: RTL and testbench

- Word-serial multi-precision adder/subtractor built around one shared 16-bit carry-lookahead adder (lookahead_adder).
- Latches two WORDS*16-bit operands on start and feeds them through the adder one 16-bit word per cycle, least-significant word first. The carry-out of each word is registered and chained into the next word's carry-in.
- Sits between a host controller and the adder datapath. It gives the design wide arithmetic without widening the combinational carry chain.

---
 rtl/multiword_add_seq_pkg.sv | 17 +
 rtl/multiword_add_seq_if.sv | 39 +++
 rtl/multiword_add_seq_adder.sv | 66 ++++++
 rtl/multiword_add_seq.sv | 113 +++++++++++
 tb/tb_multiword_add_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/multiword_add_seq_pkg.sv
// Shared types for the word-serial multi-precision adder.
//   WORD_W      : width of one datapath word (fixed by lookahead_adder)
//   seq_state_t : sequencer FSM encoding (IDLE, RUN, DONE)
//   word_t      : one datapath word
package add_pkg;

  localparam WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef logic [WORD_W-1:0] word_t;

endpackage : add_pkg

// File: rtl/multiword_add_seq_if.sv
// Host <-> sequencer bundle for multiword_add_seq.
//   start, sub, A, B          : host -> sequencer request
//   busy, done, sum, cout,
//   overflow                  : sequencer -> host status and result
//   state                     : sequencer FSM state, for observation only
//
// Handshake: start acts as the request valid, and the sequencer is ready
// exactly when busy=0 (FSM in IDLE). A request is taken on a rising clock
// edge where start=1 and the FSM is IDLE; sub, A and B are sampled on that
// same edge. While busy=1 start is ignored, not queued. done is a one-cycle
// pulse marking the cycle from which sum/cout/overflow are valid; the
// result is then held until the next accepted request.
interface multiword_add_seq_if #(
  parameter int WORDS = 4
);
  import add_pkg::*;

  logic                    start;
  logic                    sub;
  logic [WORDS*WORD_W-1:0] A;
  logic [WORDS*WORD_W-1:0] B;
  logic                    busy;
  logic                    done;
  logic [WORDS*WORD_W-1:0] sum;
  logic                    cout;
  logic                    overflow;
  seq_state_t              state;

  modport master (
    output start, sub, A, B,
    input  busy, done, sum, cout, overflow, state
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, sum, cout, overflow, state
  );

endinterface : multiword_add_seq_if

// File: rtl/multiword_add_seq_adder.sv
// lookahead_adder: 16-bit carry-lookahead adder, the only arithmetic
// datapath of the sequencer.
//   a, b : addends
//   cin  : carry in
//   s    : sum
//   cout : carry out of bit 15
// Built as four 4-bit lookahead groups; group carries are themselves
// formed from group generate/propagate terms.
module lookahead_adder
  import add_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  logic  cin,
  output word_t s,
  output logic  cout
);

  word_t      g;
  word_t      p;
  logic [3:0] gg;
  logic [3:0] gp;
  logic [4:0] cg;
  logic [WORD_W:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '0;
    cg = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    // Second-level lookahead over the four groups.
    cg[0] = cin;
    cg[1] = gg[0] | (gp[0] & cin);
    cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    // In-group carries from the group carry-in.
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = cg[k];
      c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & cg[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
    end
    c[WORD_W] = cg[4];
  end

  assign s    = p ^ c[WORD_W-1:0];
  assign cout = c[WORD_W];

endmodule : lookahead_adder

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: word-serial WORDS*16-bit adder/subtractor.
//   Clk   : system clock
//   Reset : synchronous, active-high reset
//   bus   : host bundle (slave side) - start/sub/A/B in,
//           busy/done/sum/cout/overflow/state out
// Operands are latched on an accepted start and pushed through one shared
// 16-bit lookahead adder, least-significant word first, with the carry of
// each word registered into the next. Subtraction is A + ~B + 1: B is
// inverted at latch time and the initial carry is sub.
module multiword_add_seq
  import add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  multiword_add_seq_if.slave   bus
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OP_W  = WORDS * WORD_W;

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;
  logic [OP_W-1:0]  sum_q;
  logic             cout_q;
  logic             ovf_q;

  word_t a_word;
  word_t b_word;
  word_t s_word;
  logic  add_cout;
  logic  last_word;

  assign a_word    = a_q[idx_q*WORD_W +: WORD_W];
  assign b_word    = b_q[idx_q*WORD_W +: WORD_W];
  assign last_word = (idx_q == IDX_W'(WORDS - 1));

  lookahead_adder u_adder (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry_q),
    .s    (s_word),
    .cout (add_cout)
  );

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_word) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.sub ? ~bus.B : bus.B;
            carry_q <= bus.sub;
            idx_q   <= '0;
            sum_q   <= '0;
          end
        end
        RUN: begin
          sum_q[idx_q*WORD_W +: WORD_W] <= s_word;
          carry_q <= add_cout;
          if (last_word) begin
            cout_q <= add_cout;
            // Signed overflow: operands agree in sign, result does not.
            ovf_q  <= (a_word[WORD_W-1] ~^ b_word[WORD_W-1])
                    & (s_word[WORD_W-1] ^ a_word[WORD_W-1]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.state    = state_q;

endmodule : multiword_add_seq

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq with WORDS=4 (64-bit operands).
module tb_multiword_add_seq;
  import add_pkg::*;

  localparam int WORDS = 4;
  localparam int W     = WORDS * 16;

  logic clk;
  logic reset;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  multiword_add_seq_if #(.WORDS(WORDS)) bus ();

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Drive a request at the negedge; returns 1 time unit after the edge
  // that samples it, with start already dropped.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.sub   = s;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded); busy_ok stays 1 only if
  // busy was high at every sampled point including the done cycle.
  task automatic wait_done(output int lat, output bit seen, output bit busy_ok);
    lat     = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        lat  = c;
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf);
    int lat;
    bit seen;
    bit busy_ok;
    logic [W-1:0] e;
    exp_q.push_back(exp_sum);
    start_op(a, b, s);
    check({tag, "_busy_after_start"}, W'(bus.busy), W'(1));
    wait_done(lat, seen, busy_ok);
    check({tag, "_done_seen"}, W'(seen), W'(1));
    // Accepting edge t, done visible after edge t+WORDS.
    check({tag, "_latency"}, W'(lat), W'(WORDS));
    check({tag, "_busy_during"}, W'(busy_ok), W'(1));
    e = exp_q.pop_front();
    check({tag, "_sum"}, bus.sum, e);
    check({tag, "_cout"}, W'(bus.cout), W'(exp_cout));
    check({tag, "_ovf"}, W'(bus.overflow), W'(exp_ovf));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, W'(bus.done), W'(0));
    check({tag, "_idle_after"}, W'(bus.busy), W'(0));
    check({tag, "_sum_held"}, bus.sum, e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  lat;
    bit  seen;
    bit  busy_ok;
    bit  saw_done;

    reset     = 1'b1;
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.A     = 64'h1234;
    bus.B     = 64'h5678;

    // 1. Reset for two cycles, with start asserted the whole time.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(bus.busy), W'(0));
    check("rst_done", W'(bus.done), W'(0));
    check("rst_sum", bus.sum, '0);
    check("rst_cout", W'(bus.cout), W'(0));
    check("rst_ovf", W'(bus.overflow), W'(0));
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("rst_start_ignored", W'(bus.busy), W'(0));

    // 2. Carry from word 0 into word 1.
    run_op("t2", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
           64'h0000_0000_0001_0000, 1'b0, 1'b0);
    // 3. Carry ripples through all words.
    run_op("t3", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
           64'h0, 1'b1, 1'b0);
    // 4. Subtraction with and without borrow.
    run_op("t4a", 64'h5, 64'h7, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("t4b", 64'h7, 64'h5, 1'b1,
           64'h2, 1'b1, 1'b0);
    // 5. Signed overflow in both directions.
    run_op("t5a", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("t5b", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    // Mixed words, no overflow.
    run_op("t5c", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
           64'h2222_2222_2222_2211, 1'b0, 1'b0);

    // 6a. A second start during RUN is ignored.
    start_op(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.A     = 64'hAAAA_AAAA_AAAA_AAAA;
    bus.B     = 64'h5555_5555_5555_5555;
    bus.sub   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat, seen, busy_ok);
    check("t6a_done_seen", W'(seen), W'(1));
    check("t6a_latency", W'(lat + 2), W'(WORDS));
    check("t6a_sum", bus.sum, 64'h7);
    check("t6a_cout", W'(bus.cout), W'(0));
    @(posedge clk);
    #1;
    check("t6a_idle_after", W'(bus.busy), W'(0));

    // 6b. Reset in the second RUN cycle aborts the operation.
    start_op(64'h0000_0000_0001_0001, 64'h0000_0000_0002_0002, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6b_busy", W'(bus.busy), W'(0));
    check("t6b_done", W'(bus.done), W'(0));
    check("t6b_state", W'(bus.state), W'(IDLE));
    check("t6b_sum", bus.sum, '0);
    check("t6b_cout", W'(bus.cout), W'(0));
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    check("t6b_no_done", W'(saw_done), W'(0));

    // Normal operation resumes after the abort.
    run_op("t6c", 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0001, 1'b1,
           64'hF, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule : tb_multiword_add_seq
